// File: rtl/lfsr_prbs_pkg.sv
// Shared definitions for the PRBS lock checker: FSM state encoding and a
// popcount helper used for bad-word detection and error statistics.
package lfsr_prbs_pkg;

   // Lock FSM encoding; SEARCH is the reset state.
   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } state_t;

   // Widest error word the popcount helper accepts; callers zero-extend.
   localparam int POP_MAX_W = 256;

   // Number of set bits in a (zero-extended) error word.
   function automatic int popcount(input logic [POP_MAX_W-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < POP_MAX_W; i++) begin
         n += int'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/lfsr.sv
// Combinational Fibonacci LFSR step over DATA_WIDTH bits.
// Feedback is the top state bit XOR every state bit selected by LFSR_POLY
// (bit j taps state[j-1]; the x^0 term is implied). With feed-forward the
// received bit is shifted into the state and data_out is received XOR
// predicted, i.e. a self-synchronising descrambler / checker. Without
// feed-forward the XOR result is shifted in (multiplicative scrambler).
module lfsr #(
   parameter int                    LFSR_WIDTH        = 31,
   parameter logic [LFSR_WIDTH-1:0] LFSR_POLY         = 31'h10000001,
   parameter bit                    LFSR_FEED_FORWARD = 1'b0,
   parameter bit                    REVERSE           = 1'b0,
   parameter int                    DATA_WIDTH        = 8
) (
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [LFSR_WIDTH-1:0] state_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [LFSR_WIDTH-1:0] state_out
);

   // Unrolled bit-serial walk: MSB first normally, LSB first when REVERSE.
   always_comb begin
      logic [LFSR_WIDTH-1:0] s;
      logic                  fb;
      logic                  d;
      int                    idx;
      s        = state_in;
      data_out = '0;
      fb       = 1'b0;
      d        = 1'b0;
      idx      = 0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         idx = REVERSE ? i : (DATA_WIDTH - 1 - i);
         d   = data_in[idx];
         fb  = s[LFSR_WIDTH-1];
         for (int j = 1; j < LFSR_WIDTH; j++) begin
            if (LFSR_POLY[j]) fb = fb ^ s[j-1];
         end
         data_out[idx] = fb ^ d;
         if (LFSR_FEED_FORWARD) s = {s[LFSR_WIDTH-2:0], d};
         else                   s = {s[LFSR_WIDTH-2:0], fb ^ d};
      end
      state_out = s;
   end

endmodule

// File: rtl/lfsr_prbs_check_lock.sv
// PRBS checker with lock detection. A feed-forward Fibonacci LFSR predicts
// each received word from the previously received bits; err_out is the
// registered per-bit mismatch. A SEARCH/LOCKED FSM declares lock after
// LOCK_COUNT clean words and drops it after UNLOCK_COUNT consecutive words
// with at least BAD_THRESH bit errors.
// Optional statistics (err_count / word_count) are built only when the
// macro LFSR_PRBS_CHECK_STATS_EN is defined; otherwise they read as 0.
//
// Handshake: data_in is consumed on every rising edge where data_in_valid is
// high; err_out_valid is high exactly one cycle later for each such word,
// and all checker state holds while data_in_valid is low.
module lfsr_prbs_check_lock
   import lfsr_prbs_pkg::*;
#(
   parameter int                    LFSR_WIDTH   = 31,
   parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = 31'h10000001,
   parameter int                    REVERSE      = 0,
   parameter int                    INVERT       = 1,
   parameter int                    DATA_WIDTH   = 8,
   parameter int                    LOCK_COUNT   = 16,
   parameter int                    UNLOCK_COUNT = 4,
   parameter int                    BAD_THRESH   = DATA_WIDTH / 2,
   parameter int                    CNT_WIDTH    = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_in_valid,
   input  logic                  stat_clear,
   output logic [DATA_WIDTH-1:0] err_out,
   output logic                  err_out_valid,
   output logic                  locked,
   output logic                  lock_lost,
   output logic [CNT_WIDTH-1:0]  err_count,
   output logic [CNT_WIDTH-1:0]  word_count
);

   localparam int CTR_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
   localparam int CTR_W   = $clog2(CTR_MAX + 1);
   localparam logic [CTR_W-1:0] LOCK_TGT   = CTR_W'(LOCK_COUNT);
   localparam logic [CTR_W-1:0] UNLOCK_TGT = CTR_W'(UNLOCK_COUNT);

   logic [LFSR_WIDTH-1:0] state_reg;
   logic [LFSR_WIDTH-1:0] state_next;
   logic [DATA_WIDTH-1:0] rx_word;
   logic [DATA_WIDTH-1:0] err_next;
   int                    err_pop;
   logic                  word_clean;
   logic                  word_bad;
   state_t                fsm;
   logic [CTR_W-1:0]      good_cnt;
   logic [CTR_W-1:0]      bad_cnt;

   assign rx_word    = (INVERT != 0) ? ~data_in : data_in;
   assign err_pop    = popcount(POP_MAX_W'(err_next));
   assign word_clean = (err_next == '0);
   assign word_bad   = (err_pop >= BAD_THRESH);

   lfsr #(
      .LFSR_WIDTH       (LFSR_WIDTH),
      .LFSR_POLY        (LFSR_POLY),
      .LFSR_FEED_FORWARD(1'b1),
      .REVERSE          (REVERSE != 0),
      .DATA_WIDTH       (DATA_WIDTH)
   ) u_lfsr (
      .data_in  (rx_word),
      .state_in (state_reg),
      .data_out (err_next),
      .state_out(state_next)
   );

   // Checker datapath: advance the LFSR and register the error word per valid word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= '1;
         err_out       <= '0;
         err_out_valid <= 1'b0;
      end else begin
         err_out_valid <= data_in_valid;
         if (data_in_valid) begin
            state_reg <= state_next;
            err_out   <= err_next;
         end
      end
   end

   // Lock FSM with registered locked / lock_lost outputs; counters stop at their targets.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm       <= SEARCH;
         good_cnt  <= '0;
         bad_cnt   <= '0;
         locked    <= 1'b0;
         lock_lost <= 1'b0;
      end else begin
         lock_lost <= 1'b0;
         if (data_in_valid) begin
            case (fsm)
               SEARCH: begin
                  if (!word_clean) begin
                     good_cnt <= '0;
                  end else if (good_cnt + 1'b1 >= LOCK_TGT) begin
                     good_cnt <= LOCK_TGT;
                     bad_cnt  <= '0;
                     fsm      <= LOCKED;
                     locked   <= 1'b1;
                  end else begin
                     good_cnt <= good_cnt + 1'b1;
                  end
               end
               LOCKED: begin
                  if (!word_bad) begin
                     bad_cnt <= '0;
                  end else if (bad_cnt + 1'b1 >= UNLOCK_TGT) begin
                     bad_cnt   <= '0;
                     good_cnt  <= '0;
                     fsm       <= SEARCH;
                     locked    <= 1'b0;
                     lock_lost <= 1'b1;
                  end else begin
                     bad_cnt <= bad_cnt + 1'b1;
                  end
               end
               default: begin
                  fsm    <= SEARCH;
                  locked <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef LFSR_PRBS_CHECK_STATS_EN
   logic [CNT_WIDTH:0] err_sum;
   logic               count_word;

   assign count_word = data_in_valid && (fsm == LOCKED);
   assign err_sum    = {1'b0, err_count} + (CNT_WIDTH + 1)'(err_pop);

   // Saturating statistics, counted only for words checked while locked; clear wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count  <= '0;
         word_count <= '0;
      end else if (stat_clear) begin
         err_count  <= '0;
         word_count <= '0;
      end else if (count_word) begin
         err_count <= err_sum[CNT_WIDTH] ? '1 : err_sum[CNT_WIDTH-1:0];
         if (word_count != '1) word_count <= word_count + 1'b1;
      end
   end
`else
   logic unused_stat_clear;

   assign unused_stat_clear = stat_clear;
   assign err_count         = '0;
   assign word_count        = '0;
`endif

endmodule

// File: tb/tb_lfsr_prbs_check_lock.sv
// Directed bench for lfsr_prbs_check_lock with PRBS7 parameters
// (x^7 + x^6 + 1, no inversion, 8-bit words, lock 4, unlock 2, threshold 4).
// Statistics expectations follow LFSR_PRBS_CHECK_STATS_EN: counted values
// when it is defined, constant 0 otherwise.
module tb_lfsr_prbs_check_lock;

   localparam int DW = 8;
   localparam int CW = 8;
`ifdef LFSR_PRBS_CHECK_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] data_in = '0;
   logic          data_in_valid = 1'b0;
   logic          stat_clear = 1'b0;
   logic [DW-1:0] err_out;
   logic          err_out_valid;
   logic          locked;
   logic          lock_lost;
   logic [CW-1:0] err_count;
   logic [CW-1:0] word_count;

   int n_checks = 0;
   int n_pass   = 0;

   // PRBS7 reference generator state (last 7 transmitted bits).
   logic [6:0] gen;

   typedef struct {
      logic [7:0] flip;
      logic       clr;
      logic       chk_err;
      logic [7:0] exp_err;
      logic       exp_locked;
      logic       exp_lost;
      logic [7:0] exp_wc;
      logic [7:0] exp_ec;
   } vec_t;

   vec_t vecs[20];

   lfsr_prbs_check_lock #(
      .LFSR_WIDTH  (7),
      .LFSR_POLY   (7'h41),
      .REVERSE     (0),
      .INVERT      (0),
      .DATA_WIDTH  (DW),
      .LOCK_COUNT  (4),
      .UNLOCK_COUNT(2),
      .BAD_THRESH  (4),
      .CNT_WIDTH   (CW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .data_in      (data_in),
      .data_in_valid(data_in_valid),
      .stat_clear   (stat_clear),
      .err_out      (err_out),
      .err_out_valid(err_out_valid),
      .locked       (locked),
      .lock_lost    (lock_lost),
      .err_count    (err_count),
      .word_count   (word_count)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [7:0] stat_exp(input logic [7:0] v);
      return STATS ? v : 8'h00;
   endfunction

   task automatic next_word(output logic [7:0] w);
      logic b;
      w = '0;
      for (int i = 7; i >= 0; i--) begin
         b   = gen[6] ^ gen[5];
         gen = {gen[5:0], b};
         w[i] = b;
      end
   endtask

   // Present one word for one clock edge, then sample 1 time unit after it.
   task automatic send_raw(input logic [7:0] w, input logic clr);
      @(negedge clk);
      data_in       = w;
      data_in_valid = 1'b1;
      stat_clear    = clr;
      @(posedge clk);
      #1;
      data_in_valid = 1'b0;
      stat_clear    = 1'b0;
   endtask

   task automatic send(input logic [7:0] flip, input logic clr);
      logic [7:0] w;
      next_word(w);
      send_raw(w ^ flip, clr);
   endtask

   task automatic setv(input int i, input logic [7:0] flip, input logic clr, input logic chk,
                       input logic [7:0] e, input logic lk, input logic lost,
                       input logic [7:0] wc, input logic [7:0] ec);
      vecs[i].flip       = flip;
      vecs[i].clr        = clr;
      vecs[i].chk_err    = chk;
      vecs[i].exp_err    = e;
      vecs[i].exp_locked = lk;
      vecs[i].exp_lost   = lost;
      vecs[i].exp_wc     = wc;
      vecs[i].exp_ec     = ec;
   endtask

   initial begin
      int bad;
      gen = 7'h20;  // first transmitted bit is 1, so word 1 mismatches the all-ones reset state

      //      idx flip   clr  chk  err    lk   lost wc     ec
      setv(0,  8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 8'd0);   // sync word
      setv(1,  8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'd0, 8'd0);
      setv(2,  8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'd0, 8'd0);
      setv(3,  8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'd0, 8'd0);
      setv(4,  8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'd0, 8'd0);   // 4th clean word: lock, not counted
      setv(5,  8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'd1, 8'd0);
      setv(6,  8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'd2, 8'd0);
      setv(7,  8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 8'd3, 8'd1);   // flip last bit
      setv(8,  8'h00, 1'b0, 1'b1, 8'h06, 1'b1, 1'b0, 8'd4, 8'd3);   // taps 6 and 7 bits later
      setv(9,  8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'd5, 8'd3);
      setv(10, 8'hFF, 1'b0, 1'b1, 8'hFD, 1'b1, 1'b0, 8'd6, 8'd10);  // bad word 1 (7 errors)
      setv(11, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 8'd7, 8'd18);  // bad word 2: unlock
      setv(12, 8'h00, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 8'd7, 8'd18);  // residual error, SEARCH
      setv(13, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'd7, 8'd18);
      setv(14, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'd7, 8'd18);
      setv(15, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'd7, 8'd18);
      setv(16, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'd7, 8'd18);  // relock
      setv(17, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'd8, 8'd18);
      setv(18, 8'h80, 1'b1, 1'b1, 8'h83, 1'b1, 1'b0, 8'd0, 8'd0);   // errored word + clear
      setv(19, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'd1, 8'd0);

      // Reset values while rst is held
      repeat (3) @(posedge clk);
      #1;
      check("rst err_out", 32'(err_out), 32'h0);
      check("rst err_out_valid", 32'(err_out_valid), 32'h0);
      check("rst locked", 32'(locked), 32'h0);
      check("rst lock_lost", 32'(lock_lost), 32'h0);
      check("rst err_count", 32'(err_count), 32'h0);
      check("rst word_count", 32'(word_count), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Main vector table
      for (int i = 0; i < 20; i++) begin
         send(vecs[i].flip, vecs[i].clr);
         check($sformatf("vec%0d err_out_valid", i), 32'(err_out_valid), 32'h1);
         if (vecs[i].chk_err) check($sformatf("vec%0d err_out", i), 32'(err_out), 32'(vecs[i].exp_err));
         check($sformatf("vec%0d locked", i), 32'(locked), 32'(vecs[i].exp_locked));
         check($sformatf("vec%0d lock_lost", i), 32'(lock_lost), 32'(vecs[i].exp_lost));
         check($sformatf("vec%0d word_count", i), 32'(word_count), 32'(stat_exp(vecs[i].exp_wc)));
         check($sformatf("vec%0d err_count", i), 32'(err_count), 32'(stat_exp(vecs[i].exp_ec)));
      end

      // Ten idle cycles mid-stream
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("gap%0d err_out_valid", k), 32'(err_out_valid), 32'h0);
      end
      check("gap locked", 32'(locked), 32'h1);
      check("gap word_count", 32'(word_count), 32'(stat_exp(8'd1)));
      for (int k = 0; k < 3; k++) begin
         send(8'h00, 1'b0);
         check($sformatf("resume%0d err_out", k), 32'(err_out), 32'h0);
         check($sformatf("resume%0d locked", k), 32'(locked), 32'h1);
         check($sformatf("resume%0d word_count", k), 32'(word_count), 32'(stat_exp(8'(2 + k))));
      end

      // 90 words with the first bit flipped: 3 errors each, never bad; err_count saturates
      bad = 0;
      for (int k = 0; k < 90; k++) begin
         send(8'h80, 1'b0);
         if (err_out !== 8'h83 || locked !== 1'b1) bad++;
      end
      check("flip run mismatching words", 32'(bad), 32'h0);
      check("err_count saturated", 32'(err_count), 32'(stat_exp(8'hFF)));
      check("flip run word_count", 32'(word_count), 32'(stat_exp(8'd94)));

      // 200 clean words: word_count saturates, err_count holds at all-ones
      bad = 0;
      for (int k = 0; k < 200; k++) begin
         send(8'h00, 1'b0);
         if (err_out !== 8'h00) bad++;
      end
      check("clean run mismatching words", 32'(bad), 32'h0);
      check("word_count saturated", 32'(word_count), 32'(stat_exp(8'hFF)));
      check("err_count held", 32'(err_count), 32'(stat_exp(8'hFF)));
      check("pre-reset locked", 32'(locked), 32'h1);

      // Asynchronous reset while locked, away from any clock edge
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async rst err_out", 32'(err_out), 32'h0);
      check("async rst err_out_valid", 32'(err_out_valid), 32'h0);
      check("async rst locked", 32'(locked), 32'h0);
      check("async rst lock_lost", 32'(lock_lost), 32'h0);
      check("async rst err_count", 32'(err_count), 32'h0);
      check("async rst word_count", 32'(word_count), 32'h0);
      @(posedge clk);
      #1;
      check("held rst lock_lost", 32'(lock_lost), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // All-ones state after reset: an all-zero word mispredicts only bit 1
      send_raw(8'h00, 1'b0);
      check("post-rst err_out", 32'(err_out), 32'h02);
      check("post-rst locked", 32'(locked), 32'h0);
      check("post-rst lock_lost", 32'(lock_lost), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
